// File: rtl/port_merge.sv
// port_merge: four-input packet merger for the 512-bit port fabric.
//
// Whole packets from four inputs are granted round-robin and forwarded
// flit by flit, never interleaved, to one registered output. Framing is
// taken only from the per-input end-of-frame flag.
//
// Parameters:
//   EnMask      per-input enable; a 0 bit is never granted and its D_BP stays 1
//
// Ports:
//   CLK         clock, rising edge
//   RST         synchronous active-high reset
//   D           per-input flit, eight 64-bit words
//   D_VALID     per-input flit valid
//   D_EOF       per-input last-flit flag, qualified by D_VALID
//   D_BP        per-input backpressure (1 = flit not taken this cycle)
//   Q           merged output flit
//   Q_VALID     output flit valid
//   Q_SOF       first flit of a packet, qualified by Q_VALID
//   Q_EOF       last flit of a packet, qualified by Q_VALID
//   Q_BP        downstream backpressure
//   DBG_STATE   FSM state (0 = IDLE, 1 = BUSY)
//   DBG_OWNER   input currently owning the output
//
// Handshake: an input flit moves on a rising edge when D_VALID[i] & ~D_BP[i];
// an output flit moves when Q_VALID & ~Q_BP. The output register can accept
// a new flit whenever it is empty or being drained in the same cycle.

module port_merge #(
  parameter logic [3:0] EnMask = 4'b1111
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [3:0][7:0][63:0] D,
  input  logic [3:0]            D_VALID,
  input  logic [3:0]            D_EOF,
  output logic [3:0]            D_BP,
  output logic [7:0][63:0]      Q,
  output logic                  Q_VALID,
  output logic                  Q_SOF,
  output logic                  Q_EOF,
  input  logic                  Q_BP,
  output logic                  DBG_STATE,
  output logic [1:0]            DBG_OWNER
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] owner;
  logic [1:0] owner_nxt;
  logic [1:0] last;
  logic [1:0] last_nxt;
  logic       sof_pend;
  logic       out_rdy;
  logic [3:0] req;
  logic       grant;
  logic       take;
  logic       found;
  logic [1:0] cand;

  assign out_rdy   = ~Q_VALID | ~Q_BP;
  assign req       = D_VALID & EnMask;
  assign DBG_STATE = state;
  assign DBG_OWNER = owner;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    D_BP      = 4'b1111;
    grant     = 1'b0;
    take      = 1'b0;
    found     = 1'b0;
    cand      = 2'd0;
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          grant     = 1'b1;
          state_nxt = BUSY;
          // Search upward from the input after the last served one; the
          // fourth candidate wraps back to last itself.
          for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
              found     = 1'b1;
              owner_nxt = cand;
            end
          end
        end
      end
      BUSY: begin
        D_BP[owner] = ~out_rdy;
        take        = D_VALID[owner] & out_rdy;
        if (take && D_EOF[owner]) begin
          last_nxt  = owner;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      owner    <= 2'd0;
      last     <= 2'd3;
      sof_pend <= 1'b0;
      Q        <= '0;
      Q_VALID  <= 1'b0;
      Q_SOF    <= 1'b0;
      Q_EOF    <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      // Marks the first flit accepted after each grant.
      if (grant) begin
        sof_pend <= 1'b1;
      end else if (take) begin
        sof_pend <= 1'b0;
      end
      if (take) begin
        Q       <= D[owner];
        Q_VALID <= 1'b1;
        Q_SOF   <= sof_pend;
        Q_EOF   <= D_EOF[owner];
      end else if (out_rdy) begin
        Q_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_port_merge.sv
module tb_port_merge;

  typedef struct packed {
    logic [31:0]  cyc;
    logic         sof;
    logic         eof;
    logic [511:0] data;
  } obs_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance (all inputs enabled)
  logic [3:0][7:0][63:0] d = '0;
  logic [3:0]            d_valid = '0;
  logic [3:0]            d_eof = '0;
  logic [3:0]            d_bp;
  logic [7:0][63:0]      q;
  logic                  q_valid, q_sof, q_eof;
  logic                  q_bp = 1'b0;
  logic                  dbg_state;
  logic [1:0]            dbg_owner;

  // masked instance (input 1 disabled)
  logic [3:0][7:0][63:0] m_d = '0;
  logic [3:0]            m_d_valid = '0;
  logic [3:0]            m_d_eof = '0;
  logic [3:0]            m_d_bp;
  logic [7:0][63:0]      m_q;
  logic                  m_q_valid, m_q_sof, m_q_eof;
  logic                  m_q_bp = 1'b0;
  logic                  m_dbg_state;
  logic [1:0]            m_dbg_owner;

  // fully disabled instance, fed from the main stimulus
  logic [3:0]            z_d_bp;
  logic [7:0][63:0]      z_q;
  logic                  z_q_valid, z_q_sof, z_q_eof;
  logic                  z_dbg_state;
  logic [1:0]            z_dbg_owner;

  port_merge #(.EnMask(4'b1111)) dut (
    .CLK(clk), .RST(rst), .D(d), .D_VALID(d_valid), .D_EOF(d_eof), .D_BP(d_bp),
    .Q(q), .Q_VALID(q_valid), .Q_SOF(q_sof), .Q_EOF(q_eof), .Q_BP(q_bp),
    .DBG_STATE(dbg_state), .DBG_OWNER(dbg_owner)
  );

  port_merge #(.EnMask(4'b1101)) dut_m (
    .CLK(clk), .RST(rst), .D(m_d), .D_VALID(m_d_valid), .D_EOF(m_d_eof), .D_BP(m_d_bp),
    .Q(m_q), .Q_VALID(m_q_valid), .Q_SOF(m_q_sof), .Q_EOF(m_q_eof), .Q_BP(m_q_bp),
    .DBG_STATE(m_dbg_state), .DBG_OWNER(m_dbg_owner)
  );

  port_merge #(.EnMask(4'b0000)) dut_z (
    .CLK(clk), .RST(rst), .D(d), .D_VALID(d_valid), .D_EOF(d_eof), .D_BP(z_d_bp),
    .Q(z_q), .Q_VALID(z_q_valid), .Q_SOF(z_q_sof), .Q_EOF(z_q_eof), .Q_BP(q_bp),
    .DBG_STATE(z_dbg_state), .DBG_OWNER(z_dbg_owner)
  );

  // scoreboard: per-input expected flits {sof, eof, data}, observed output log
  logic [513:0] exp_q[4][$];
  obs_t         obs_q[$];
  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (!rst && q_valid && !q_bp) obs_q.push_back({32'(cyc), q_sof, q_eof, 512'(q)});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired: run did not finish (%0d/%0d checks passed)", n_pass, n_total);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    d_valid = '0;
    d_eof = '0;
    m_d_valid = '0;
    q_bp = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_sb();
    obs_q.delete();
    for (int i = 0; i < 4; i++) exp_q[i].delete();
  endtask

  task automatic wait_accept(input int src);
    bit ok;
    int t;
    ok = 1'b0;
    t = 0;
    while (!ok && t < 300) begin
      @(negedge clk);
      if (d_valid[src] && !d_bp[src]) ok = 1'b1;
      t++;
    end
    n_total++;
    if (!ok) $display("FAIL accept_timeout src=%0d waited=%0d cycles required accept", src, t);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  // Sends one packet of random flits tagged with src in word0[63:56].
  task automatic send_pkt(input int src, input int nflits, input int gap_at, input int gap_len);
    logic [7:0][63:0] f;
    logic sof_b, eof_b;
    for (int k = 0; k < nflits; k++) begin
      for (int w = 0; w < 8; w++) f[w] = {$urandom, $urandom};
      f[0][63:56] = 8'(src);
      sof_b = (k == 0);
      eof_b = (k == nflits - 1);
      exp_q[src].push_back({sof_b, eof_b, 512'(f)});
      d[src] = f;
      d_eof[src] = eof_b;
      d_valid[src] = 1'b1;
      wait_accept(src);
      if (k == gap_at && !eof_b) begin
        d_valid[src] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
    d_valid[src] = 1'b0;
    d_eof[src] = 1'b0;
  endtask

  task automatic rand_source(input int src);
    int dly, npk, n, ga, gl;
    dly = $urandom_range(0, 5);
    if (dly > 0) begin
      repeat (dly) @(posedge clk);
      #1;
    end
    npk = $urandom_range(1, 3);
    for (int p = 0; p < npk; p++) begin
      n = $urandom_range(1, 5);
      ga = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      gl = $urandom_range(1, 3);
      send_pkt(src, n, ga, gl);
    end
    done_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_total++; if (q_valid !== 1'b0) $display("FAIL reset_q_valid got=%0b exp=0", q_valid); else n_pass++;
    n_total++; if (q_sof !== 1'b0) $display("FAIL reset_q_sof got=%0b exp=0", q_sof); else n_pass++;
    n_total++; if (q_eof !== 1'b0) $display("FAIL reset_q_eof got=%0b exp=0", q_eof); else n_pass++;
    n_total++; if (q !== '0) $display("FAIL reset_q got=%h exp=0", q); else n_pass++;
    n_total++; if (d_bp !== 4'b1111) $display("FAIL reset_d_bp got=%b exp=1111", d_bp); else n_pass++;
    n_total++; if (dbg_state !== 1'b0) $display("FAIL reset_state got=%0b exp=0", dbg_state); else n_pass++;
    n_total++; if (m_d_bp !== 4'b1111) $display("FAIL reset_m_d_bp got=%b exp=1111", m_d_bp); else n_pass++;
    n_total++; if (z_d_bp !== 4'b1111) $display("FAIL reset_z_d_bp got=%b exp=1111", z_d_bp); else n_pass++;
  endtask

  task automatic test_single_packet();
    logic [7:0][63:0] fa, fb;
    int t0;
    clear_sb();
    fa = '0;
    fa[0] = {8'h1, 56'h1};
    fa[7] = 64'd5;
    fb = '0;
    for (int w = 1; w <= 5; w++) fb[w] = 64'(w);
    t0 = cyc;
    d[0] = fa;
    d_eof[0] = 1'b0;
    d_valid[0] = 1'b1;
    wait_accept(0);
    d[0] = fb;
    d_eof[0] = 1'b1;
    wait_accept(0);
    d_valid[0] = 1'b0;
    d_eof[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (obs_q.size() != 2) $display("FAIL single_count got=%0d exp=2", obs_q.size());
    else begin
      n_pass++;
      n_total++; if (obs_q[0].data !== 512'(fa)) $display("FAIL single_flitA got=%h exp=%h", obs_q[0].data, fa); else n_pass++;
      n_total++; if ({obs_q[0].sof, obs_q[0].eof} !== 2'b10) $display("FAIL single_flitA_flags got=%b exp=10", {obs_q[0].sof, obs_q[0].eof}); else n_pass++;
      n_total++; if (obs_q[0].cyc !== 32'(t0 + 2)) $display("FAIL single_latency got=%0d exp=%0d", obs_q[0].cyc, t0 + 2); else n_pass++;
      n_total++; if (obs_q[1].data !== 512'(fb)) $display("FAIL single_flitB got=%h exp=%h", obs_q[1].data, fb); else n_pass++;
      n_total++; if ({obs_q[1].sof, obs_q[1].eof} !== 2'b01) $display("FAIL single_flitB_flags got=%b exp=01", {obs_q[1].sof, obs_q[1].eof}); else n_pass++;
      n_total++; if (obs_q[1].cyc !== 32'(t0 + 3)) $display("FAIL single_flitB_cycle got=%0d exp=%0d", obs_q[1].cyc, t0 + 3); else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int pend[4];
    int last_m, t0, prev, exp_cyc;
    obs_t o;
    logic [513:0] e;
    apply_reset();
    clear_sb();
    // Arbitration model: every input is requesting at each grant point.
    pend = '{2, 2, 2, 2};
    last_m = 3;
    for (int n = 0; n < 8; n++) begin
      bit got;
      got = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (last_m + k) % 4;
        if (!got && pend[c] > 0) begin
          got = 1'b1;
          order.push_back(c);
          pend[c]--;
          last_m = c;
        end
      end
    end
    t0 = cyc;
    fork
      begin send_pkt(0, 3, -1, 0); send_pkt(0, 3, -1, 0); end
      begin send_pkt(1, 3, -1, 0); send_pkt(1, 3, -1, 0); end
      begin send_pkt(2, 3, -1, 0); send_pkt(2, 3, -1, 0); end
      begin send_pkt(3, 3, -1, 0); send_pkt(3, 3, -1, 0); end
    join
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (obs_q.size() != 24) $display("FAIL rr_count got=%0d exp=24", obs_q.size());
    else begin
      n_pass++;
      prev = 0;
      for (int p = 0; p < 8; p++) begin
        for (int j = 0; j < 3; j++) begin
          o = obs_q[p * 3 + j];
          n_total++;
          if (int'(o.data[63:56]) != order[p]) $display("FAIL rr_src pkt=%0d flit=%0d got=%0d exp=%0d", p, j, o.data[63:56], order[p]);
          else n_pass++;
          n_total++;
          if (exp_q[order[p]].size() == 0) $display("FAIL rr_data pkt=%0d flit=%0d got=extra flit exp=none", p, j);
          else begin
            e = exp_q[order[p]].pop_front();
            if ({o.sof, o.eof, o.data} !== e) $display("FAIL rr_data pkt=%0d flit=%0d got=%h exp=%h", p, j, {o.sof, o.eof, o.data}, e);
            else n_pass++;
          end
          if (p == 0 && j == 0) exp_cyc = t0 + 2;
          else if (j == 0) exp_cyc = prev + 2;
          else exp_cyc = prev + 1;
          n_total++;
          if (o.cyc !== 32'(exp_cyc)) $display("FAIL rr_timing pkt=%0d flit=%0d got=%0d exp=%0d", p, j, o.cyc, exp_cyc);
          else n_pass++;
          prev = int'(o.cyc);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0][63:0] snap;
    logic [513:0] e;
    bit found;
    clear_sb();
    fork
      send_pkt(2, 4, -1, 0);
      begin
        found = 1'b0;
        for (int t = 0; t < 50 && !found; t++) begin
          @(posedge clk);
          #1;
          if (q_valid && !q_sof) found = 1'b1;
        end
        n_total++;
        if (!found) $display("FAIL bp_second_flit got=not seen exp=seen");
        else begin
          n_pass++;
          q_bp = 1'b1;
          snap = q;
          for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            n_total++; if (q !== snap) $display("FAIL bp_q_stable cycle=%0d got=%h exp=%h", s, q, snap); else n_pass++;
            n_total++; if (q_valid !== 1'b1) $display("FAIL bp_q_valid cycle=%0d got=%0b exp=1", s, q_valid); else n_pass++;
            n_total++; if (d_bp[2] !== 1'b1) $display("FAIL bp_d_bp2 cycle=%0d got=%0b exp=1", s, d_bp[2]); else n_pass++;
            @(posedge clk);
            #1;
          end
          q_bp = 1'b0;
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (obs_q.size() != 4) $display("FAIL bp_count got=%0d exp=4", obs_q.size());
    else begin
      n_pass++;
      for (int j = 0; j < 4; j++) begin
        e = exp_q[2].pop_front();
        n_total++;
        if ({obs_q[j].sof, obs_q[j].eof, obs_q[j].data} !== e) $display("FAIL bp_data flit=%0d got=%h exp=%h", j, {obs_q[j].sof, obs_q[j].eof, obs_q[j].data}, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_enmask();
    logic [7:0][63:0] f3[2];
    logic [7:0][63:0] f1;
    int idx, got;
    bit acc;
    for (int w = 0; w < 8; w++) f1[w] = {$urandom, $urandom};
    for (int j = 0; j < 2; j++)
      for (int w = 0; w < 8; w++) f3[j][w] = {$urandom, $urandom};
    m_d[1] = f1;
    m_d_eof[1] = 1'b0;
    m_d_valid[1] = 1'b1;
    m_d[3] = f3[0];
    m_d_eof[3] = 1'b0;
    m_d_valid[3] = 1'b1;
    idx = 0;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_total++; if (m_d_bp[1] !== 1'b1) $display("FAIL mask_d_bp1 cycle=%0d got=%0b exp=1", c, m_d_bp[1]); else n_pass++;
      if (m_q_valid) begin
        n_total++;
        if (got >= 2) $display("FAIL mask_extra_flit got=%h exp=none", m_q);
        else if ({m_q_sof, m_q_eof, m_q} !== {got == 0, got == 1, 512'(f3[got])})
          $display("FAIL mask_data flit=%0d got=%h exp=%h", got, {m_q_sof, m_q_eof, m_q}, {got == 0, got == 1, 512'(f3[got])});
        else n_pass++;
        got++;
      end
      acc = m_d_valid[3] && !m_d_bp[3];
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx == 2) begin
          m_d_valid[3] = 1'b0;
          m_d_eof[3] = 1'b0;
        end else begin
          m_d[3] = f3[1];
          m_d_eof[3] = 1'b1;
        end
      end
    end
    n_total++; if (got != 2) $display("FAIL mask_count got=%0d exp=2", got); else n_pass++;
    m_d_valid = '0;
  endtask

  task automatic test_owner_gap();
    logic [513:0] e;
    clear_sb();
    fork
      send_pkt(0, 4, 1, 5);
      begin
        repeat (3) @(posedge clk);
        #1;
        send_pkt(1, 2, -1, 0);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (obs_q.size() != 6) $display("FAIL gap_count got=%0d exp=6", obs_q.size());
    else begin
      n_pass++;
      for (int j = 0; j < 6; j++) begin
        int src;
        src = (j < 4) ? 0 : 1;
        n_total++;
        if (exp_q[src].size() == 0) $display("FAIL gap_data flit=%0d got=extra exp=none", j);
        else begin
          e = exp_q[src].pop_front();
          if ({obs_q[j].sof, obs_q[j].eof, obs_q[j].data} !== e) $display("FAIL gap_data flit=%0d got=%h exp=%h", j, {obs_q[j].sof, obs_q[j].eof, obs_q[j].data}, e);
          else n_pass++;
        end
      end
      n_total++;
      if (obs_q[4].cyc !== obs_q[3].cyc + 32'd2) $display("FAIL gap_bubble got=%0d exp=%0d", obs_q[4].cyc, obs_q[3].cyc + 32'd2);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0][63:0] f0, f1;
    logic [513:0] e;
    clear_sb();
    for (int w = 0; w < 8; w++) begin
      f0[w] = {$urandom, $urandom};
      f1[w] = {$urandom, $urandom};
    end
    d[0] = f0;
    d_eof[0] = 1'b0;
    d_valid[0] = 1'b1;
    wait_accept(0);
    d[0] = f1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    d_valid[0] = 1'b0;
    n_total++; if (q_valid !== 1'b0) $display("FAIL rstmid_q_valid got=%0b exp=0", q_valid); else n_pass++;
    n_total++; if (d_bp !== 4'b1111) $display("FAIL rstmid_d_bp got=%b exp=1111", d_bp); else n_pass++;
    n_total++; if (dbg_state !== 1'b0) $display("FAIL rstmid_state got=%0b exp=0", dbg_state); else n_pass++;
    clear_sb();
    send_pkt(0, 2, -1, 0);
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (obs_q.size() != 2) $display("FAIL rstmid_count got=%0d exp=2", obs_q.size());
    else begin
      n_pass++;
      for (int j = 0; j < 2; j++) begin
        e = exp_q[0].pop_front();
        n_total++;
        if ({obs_q[j].sof, obs_q[j].eof, obs_q[j].data} !== e) $display("FAIL rstmid_data flit=%0d got=%h exp=%h", j, {obs_q[j].sof, obs_q[j].eof, obs_q[j].data}, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [513:0] e;
    int tag, cur;
    bit in_pkt;
    clear_sb();
    done_cnt = 0;
    fork
      rand_source(0);
      rand_source(1);
      rand_source(2);
      rand_source(3);
      begin
        for (int g = 0; g < 3000 && done_cnt < 4; g++) begin
          @(negedge clk);
          n_total++;
          if ({z_d_bp, z_q_valid} !== 5'b11110) $display("FAIL zero_mask got=%b exp=11110", {z_d_bp, z_q_valid});
          else n_pass++;
          @(posedge clk);
          #1;
          q_bp = ($urandom_range(0, 3) == 0);
        end
        q_bp = 1'b0;
      end
    join
    q_bp = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    in_pkt = 1'b0;
    cur = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      o = obs_q[i];
      tag = int'(o.data[63:56]);
      if (in_pkt) begin
        n_total++;
        if (tag != cur) $display("FAIL rand_interleave flit=%0d got=%0d exp=%0d", i, tag, cur);
        else n_pass++;
      end
      n_total++;
      if (tag > 3 || exp_q[tag & 3].size() == 0) $display("FAIL rand_unexpected flit=%0d got=src %0d exp=pending flit", i, tag);
      else begin
        e = exp_q[tag].pop_front();
        if ({o.sof, o.eof, o.data} !== e) $display("FAIL rand_data flit=%0d got=%h exp=%h", i, {o.sof, o.eof, o.data}, e);
        else n_pass++;
      end
      in_pkt = !o.eof;
      cur = tag;
    end
    for (int s = 0; s < 4; s++) begin
      n_total++;
      if (exp_q[s].size() != 0) $display("FAIL rand_missing src=%0d got=%0d left exp=0", s, exp_q[s].size());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_enmask();
    test_owner_gap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/port_merge.md
# port_merge

Four-input packet merger for the 512-bit port fabric, and the converging counterpart of the router's one-to-four split. It accepts whole packets on four port inputs, typically the four router outputs or four independent packet sources. Packets are granted round-robin and are never interleaved. The granted packet is forwarded flit by flit to a single registered port output, which can feed the port-to-AXIS bridge or another router. Framing comes only from the per-input end-of-frame flag; header contents are not parsed.

## Interface
- EnMask, 4'b1111: per-input enable. A 0 bit means that input is never granted and its D_BP is held at 1.
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- D  in  [3:0][7:0][63:0]  per-input flit, eight 64-bit words.
- D_VALID  in  [3:0]  per-input flit valid.
- D_EOF  in  [3:0]  per-input flag marking the last flit of a packet; qualified by D_VALID.
- D_BP  out  [3:0]  per-input backpressure; 1 means the flit is not taken this cycle.
- Q  out  [7:0][63:0]  merged output flit.
- Q_VALID  out  1  output flit valid.
- Q_SOF  out  1  first flit of the packet; qualified by Q_VALID.
- Q_EOF  out  1  last flit of the packet; qualified by Q_VALID.
- Q_BP  in  1  downstream backpressure.

## Operation
- Transfer rules:
  - An input flit transfers when D_VALID[i] & ~D_BP[i] at a rising edge.
  - An output flit transfers when Q_VALID & ~Q_BP at a rising edge.
- Output readiness: out_rdy = ~Q_VALID | ~Q_BP. This is combinational.
- State IDLE:
  - D_BP = 4'b1111.
  - Requests are req = D_VALID & EnMask.
  - If req ≠ 0, owner takes the first requesting input after last, searching upward and wrapping 3→0, and the state goes to BUSY.
  - If req = 0, the state stays IDLE.
- State BUSY:
  - D_BP[owner] = ~out_rdy. Every other D_BP bit is 1.
  - On a transfer from owner:
    - D[owner] is loaded into Q and Q_VALID is set.
    - Q_EOF takes D_EOF[owner].
    - Q_SOF is 1 if this is the first flit accepted since the grant.
  - If the transferred flit has D_EOF, then last ← owner and the next state is IDLE.
  - If D_VALID[owner] drops mid-packet, owner is kept. Other inputs stay blocked until EOF; there is no timeout.
- Output register:
  - If out_rdy and there is no input transfer, Q_VALID clears to 0. Q, Q_SOF and Q_EOF keep their values but are don't-care.
  - If Q_VALID & Q_BP, Q, Q_VALID, Q_SOF and Q_EOF all hold unchanged.
- A single-flit packet (first flit carries D_EOF) produces Q_SOF = Q_EOF = 1 on the same flit.
- EnMask = 0: the block stays IDLE permanently with all D_BP = 1.
- Flits are carried through unchanged, bit for bit. No words are reordered.

## Timing
- Reset values: Q = 0, Q_VALID = 0, Q_SOF = 0, Q_EOF = 0, state = IDLE, last = 3 (so input 0 has first priority), D_BP = 4'b1111.
- RST applied mid-packet: on the next edge the block returns to the reset values and the partial packet is dropped. The upstream source must restart the packet.
- Latency:
  - Request seen in IDLE at edge N.
  - First flit accepted at edge N+1.
  - Q_VALID high after edge N+1, i.e. during cycle N+1 to N+2.
  - With Q_BP = 0, each following flit takes one cycle.
- Packet gap: exactly one IDLE bubble cycle between consecutive packets, including back-to-back packets from the same input.
- Throughput: one flit per cycle within a packet while Q_BP = 0 and the owner keeps D_VALID high.
- Backpressure: D_BP[owner] follows Q_BP combinationally when Q_VALID = 1. There is no skid storage and no flit is lost or duplicated.

## Test plan
- Single packet on input 0:
  - Stimulus: flit A with word0 = {8'h1, 56'h1} and word7 = 5, then flit B with words 1..5 and D_EOF = 1; Q_BP = 0.
  - Required: Q shows A with Q_SOF = 1, then B with Q_EOF = 1, on consecutive cycles. First Q_VALID is 2 edges after the request.
- Four simultaneous 3-flit packets, repeated twice:
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Required: exactly one bubble between packets and no interleaving of flits from different inputs.
- Q_BP = 1 for 3 cycles in the middle of a 4-flit packet on input 2:
  - Required: Q and Q_VALID stable for those cycles and D_BP[2] = 1.
  - Required: all 4 flits delivered exactly once, in order.
- EnMask = 4'b1101 with input 1 always valid and input 3 valid:
  - Required: only input 3 is served and D_BP[1] stays 1.
- Owner D_VALID gap of 5 cycles mid-packet while input 1 requests:
  - Required: input 1 remains blocked until the owner's EOF, then is granted after the bubble.
- RST pulsed for 1 cycle during flit 2 of 4:
  - Required: Q_VALID = 0 and D_BP = 4'b1111 after the reset edge.
  - Required: the next packet from input 0 starts with Q_SOF = 1.
